fxp_mul_array_stream: RTL and testbench

Multi-lane signed fixed-point multiplier array with a valid/ready streaming interface and configurable pipeline depth. Each lane supports per-beat selectable rounding and saturation, a per-lane enable mask and per-lane overflow flags. A saturating overflow event counter is included. The block sits between the feature/weight fetch stage and the accumulator in the convolution datapath, and replaces the fixed-latency, always-on multiplier bank.

---
 rtl/fxp_mul_array_stream.sv | 136 +++++++++++++
 tb/tb_fxp_mul_array_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_mul_array_stream.sv
`default_nettype none
// ============================================================================
// Module   : fxp_mul_array_stream
// Brief    : Multi-lane signed fixed-point multiplier array with per-beat
//            rounding/saturation, lane masking, overflow flags and a
//            saturating overflow event counter behind a valid/ready pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module fxp_mul_array_stream #(
    parameter int NUM_LANES   = 32,
    parameter int WIDTH       = 14,
    parameter int FRAC_BITS   = 7,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LANES*WIDTH-1:0]     a,
    input  logic [NUM_LANES*WIDTH-1:0]     b,
    input  logic [NUM_LANES-1:0]           lane_mask,
    input  logic                           round_mode,
    input  logic                           sat_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*WIDTH-1:0]     result,
    output logic [NUM_LANES-1:0]           ovf,
    output logic [CNT_WIDTH-1:0]           ovf_count,
    input  logic                           ovf_clear
);

    localparam int c_PROD_W = 2 * WIDTH;
    localparam logic signed [c_PROD_W-1:0] c_HALF = c_PROD_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [c_PROD_W-1:0] c_MAX  = {{(c_PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [c_PROD_W-1:0] c_MIN  = {{(c_PROD_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_MAX_N = c_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_MIN_N = c_MIN[WIDTH-1:0];

    logic [NUM_LANES*WIDTH-1:0] w_res;
    logic [NUM_LANES-1:0]       w_ovf;

    logic [NUM_LANES*WIDTH-1:0] r_data [PIPE_STAGES];
    logic [NUM_LANES-1:0]       r_ovf  [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]     r_valid;
    logic [PIPE_STAGES-1:0]     w_ready;
    logic [CNT_WIDTH-1:0]       r_ovf_count;

    // The full multiply/round/clamp is resolved before stage 0; later stages only carry it.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic signed [c_PROD_W-1:0] w_ax;
        logic signed [c_PROD_W-1:0] w_bx;
        logic signed [c_PROD_W-1:0] w_rnd;
        logic signed [c_PROD_W-1:0] w_q;
        logic                       w_hi;
        logic                       w_lo;
        logic [WIDTH-1:0]           w_lane_res;
        logic                       w_lane_ovf;

        assign w_ax  = {{WIDTH{a[l*WIDTH+WIDTH-1]}}, a[l*WIDTH +: WIDTH]};
        assign w_bx  = {{WIDTH{b[l*WIDTH+WIDTH-1]}}, b[l*WIDTH +: WIDTH]};
        assign w_rnd = round_mode ? c_HALF : '0;
        assign w_q   = (w_ax * w_bx + w_rnd) >>> FRAC_BITS;
        assign w_hi  = (w_q > c_MAX);
        assign w_lo  = (w_q < c_MIN);

        always_comb begin
            w_lane_res = '0;
            w_lane_ovf = 1'b0;
            if (lane_mask[l]) begin
                w_lane_ovf = w_hi | w_lo;
                if (sat_en && w_hi) begin
                    w_lane_res = c_MAX_N;
                end else if (sat_en && w_lo) begin
                    w_lane_res = c_MIN_N;
                end else begin
                    w_lane_res = w_q[WIDTH-1:0];
                end
            end
        end

        assign w_res[l*WIDTH +: WIDTH] = w_lane_res;
        assign w_ovf[l]                = w_lane_ovf;
    end

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        logic [NUM_LANES*WIDTH-1:0] w_in_data;
        logic [NUM_LANES-1:0]       w_in_ovf;
        logic                       w_in_valid;

        if (s == 0) begin : g_head
            assign w_in_data  = w_res;
            assign w_in_ovf   = w_ovf;
            assign w_in_valid = in_valid;
        end else begin : g_body
            assign w_in_data  = r_data[s-1];
            assign w_in_ovf   = r_ovf[s-1];
            assign w_in_valid = r_valid[s-1];
        end

        // A stage can take new data unless it and every stage ahead of it is full and stalled.
        assign w_ready[s] = ~(&r_valid[PIPE_STAGES-1:s]) | out_ready;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_valid[s] <= 1'b0;
                r_data[s]  <= '0;
                r_ovf[s]   <= '0;
            end else if (w_ready[s]) begin
                r_valid[s] <= w_in_valid;
                if (w_in_valid) begin
                    r_data[s] <= w_in_data;
                    r_ovf[s]  <= w_in_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf_count <= '0;
        end else if (ovf_clear) begin
            r_ovf_count <= '0;
        end else if (out_valid && out_ready && (|ovf) && (r_ovf_count != '1)) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_valid[PIPE_STAGES-1];
    assign result    = r_data[PIPE_STAGES-1];
    assign ovf       = r_ovf[PIPE_STAGES-1];
    assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_fxp_mul_array_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fxp_mul_array_stream
// Brief    : Directed scoreboard bench for the fixed-point multiplier array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fxp_mul_array_stream;

    localparam int NL = 32;
    localparam int W  = 14;
    localparam int F  = 7;
    localparam int PS = 2;
    localparam int CW = 16;

    typedef struct packed {
        logic [NL*W-1:0] res;
        logic [NL-1:0]   ovf;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [NL*W-1:0] a;
    logic [NL*W-1:0] b;
    logic [NL-1:0]   lane_mask;
    logic            round_mode;
    logic            sat_en;
    logic            out_valid;
    logic            out_ready;
    logic [NL*W-1:0] result;
    logic [NL-1:0]   ovf;
    logic [CW-1:0]   ovf_count;
    logic            ovf_clear;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    fxp_mul_array_stream #(
        .NUM_LANES(NL), .WIDTH(W), .FRAC_BITS(F), .PIPE_STAGES(PS), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .lane_mask(lane_mask), .round_mode(round_mode), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf),
        .ovf_count(ovf_count), .ovf_clear(ovf_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NL*W-1:0] obs, input logic [NL*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic in plain 64-bit integers.
    function automatic exp_t model(input logic [NL*W-1:0] av, input logic [NL*W-1:0] bv,
                                   input logic [NL-1:0] m, input logic rnd, input logic sat);
        exp_t   e;
        longint pa, pb, q, v;
        longint maxv, minv;
        maxv = (64'sd1 <<< (W-1)) - 1;
        minv = -(64'sd1 <<< (W-1));
        e = '0;
        for (int l = 0; l < NL; l++) begin
            pa = longint'($signed(av[l*W +: W]));
            pb = longint'($signed(bv[l*W +: W]));
            q  = pa * pb;
            if (rnd) q = q + (64'sd1 <<< (F-1));
            q = q >>> F;
            if (m[l]) begin
                e.ovf[l] = (q > maxv) || (q < minv);
                v = q;
                if (sat && q > maxv) v = maxv;
                if (sat && q < minv) v = minv;
                e.res[l*W +: W] = v[W-1:0];
            end
        end
        return e;
    endfunction

    task automatic send(input logic [NL*W-1:0] av, input logic [NL*W-1:0] bv,
                        input logic [NL-1:0] m, input logic rnd, input logic sat);
        logic done;
        a = av; b = bv; lane_mask = m; round_mode = rnd; sat_en = sat;
        in_valid = 1'b1;
        sb.push_back(model(av, bv, m, rnd, sat));
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        chk("send_accept", done, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic empty;
        empty = 1'b0;
        for (int n = 0; n < 30 && !empty; n++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) empty = 1'b1;
        end
        chk("drain_empty", empty, 1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", out_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("beat_result", result, e.res);
                chk("beat_ovf", ovf, e.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NL*W-1:0] av, bv;
        logic            found;

        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; lane_mask = '0;
        round_mode = 1'b0; sat_en = 1'b0; out_ready = 1'b1; ovf_clear = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ovf_count", ovf_count, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        // Latency: 1.5 * 2.0 = 3.0 appears exactly PIPE_STAGES cycles after transfer
        @(posedge clk); #1;
        av = '0; bv = '0;
        av[0 +: W] = 14'd192; bv[0 +: W] = 14'd256;
        send(av, bv, '1, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_cycle1_out_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_out_valid", out_valid, 1);
        chk("lat_lane0_result", result[W-1:0], 14'd384);
        chk("lat_ovf", ovf, 0);
        drain();

        // Rounding at the half-LSB boundary, positive and negative, back-to-back
        av = '0; bv = '0;
        av[0 +: W] = 14'd1; bv[0 +: W] = 14'd64;
        send(av, bv, '1, 1'b0, 1'b0);
        send(av, bv, '1, 1'b1, 1'b0);
        av[0 +: W] = '1;
        send(av, bv, '1, 1'b0, 1'b0);
        send(av, bv, '1, 1'b1, 1'b0);
        drain();

        // Random full-lane beats with random mask and modes
        for (int k = 0; k < 6; k++) begin
            for (int l = 0; l < NL; l++) begin
                av[l*W +: W] = W'($urandom);
                bv[l*W +: W] = W'($urandom);
            end
            send(av, bv, NL'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();

        // Overflow, saturation, masking and the event counter
        @(posedge clk); #1 ovf_clear = 1'b1;
        @(posedge clk); #1 ovf_clear = 1'b0;
        chk("cnt_cleared", ovf_count, 0);
        av = {NL{14'h1FFF}};
        send(av, av, 32'h0000_0001, 1'b0, 1'b1);
        send(av, av, '1, 1'b0, 1'b0);
        drain();
        chk("cnt_two", ovf_count, 2);

        send(av, av, '1, 1'b0, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        chk("clr_beat_seen", found, 1);
        ovf_clear = 1'b1;
        chk("cnt_before_clr", ovf_count, 2);
        @(posedge clk); #1 ovf_clear = 1'b0;
        chk("cnt_clear_priority", ovf_count, 0);
        drain();

        // Backpressure: two beats fill the pipe, the third must wait
        out_ready = 1'b0;
        bv = {NL{14'd5}};
        for (int l = 0; l < NL; l++) av[l*W +: W] = W'(l + 1);
        send(av, bv, '1, 1'b0, 1'b0);
        for (int l = 0; l < NL; l++) av[l*W +: W] = W'(l + 40);
        send(av, bv, '1, 1'b1, 1'b0);
        for (int l = 0; l < NL; l++) av[l*W +: W] = W'(l + 80);
        a = av; b = bv; lane_mask = 32'hF0F0_F0F0; round_mode = 1'b0; sat_en = 1'b1;
        in_valid = 1'b1;
        sb.push_back(model(av, bv, 32'hF0F0_F0F0, 1'b0, 1'b1));
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head_result", result, sb[0].res);
        @(negedge clk);
        chk("bp_stall_hold", result, sb[0].res);
        chk("bp_stall_ovf", ovf, sb[0].ovf);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_exit1_valid", out_valid, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_exit2_valid", out_valid, 1);
        @(negedge clk);
        chk("bp_exit3_valid", out_valid, 1);
        drain();

        // Reset with beats in flight
        av = {NL{14'h1FFF}};
        send(av, av, '1, 1'b0, 1'b1);
        drain();
        chk("cnt_pre_reset", ovf_count, 1);
        out_ready = 1'b0;
        send(av, av, '1, 1'b0, 1'b1);
        send(av, av, '1, 1'b1, 1'b0);
        @(negedge clk);
        chk("inflight_valid", out_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_ovf_count", ovf_count, 0);
        sb.delete();
        @(posedge clk); #1 rst = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("post_rst_no_beat", out_valid, 0);
        end
        chk("sb_final_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
